// File: rtl/lycan_globals.sv
// Shared widths and state type for the USB RX path.
// Arbiter FSM states live here so other blocks can decode them.
package lycan_globals;

  localparam int usb_packet_width     = 32;
  localparam int periph_address_width = 3;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    CAPTURE,
    SEND
  } arb_state_t;

endpackage

// File: rtl/periph_rx_arbiter_rr.sv
// Round-robin first-set search over a request vector.
// Scans from start upward with wrap; purely combinational.
module rr_priority_select
  import lycan_globals::*;
#(
  parameter int N  = 8,
  parameter int AW = periph_address_width
) (
  input  logic [N-1:0]  req,
  input  logic [AW-1:0] start,
  output logic          found,
  output logic [AW-1:0] idx
);

  localparam logic [AW:0] WRAP = (AW+1)'(N);

  // Walk offsets high to low so the nearest hit overwrites the rest
  always_comb begin
    logic [AW:0] j;
    j     = '0;
    found = 1'b0;
    idx   = '0;
    for (int i = N - 1; i >= 0; i--) begin
      j = {1'b0, start} + (AW+1)'(i);
      if (j >= WRAP) begin
        j = j - WRAP;
      end
      if (req[j[AW-1:0]]) begin
        found = 1'b1;
        idx   = j[AW-1:0];
      end
    end
  end

endmodule

// File: rtl/periph_rx_arbiter.sv
// Moves packets from peripheral RX FIFOs to the USB TX path.
// Almost-full FIFOs win arbitration; bursts are capped at BURST_LEN.
module periph_rx_arbiter
  import lycan_globals::*;
#(
  parameter int NUM_PERIPHS = 8,
  parameter int BURST_LEN   = 4
) (
  input  logic                                          clk,
  input  logic                                          rst,
  input  logic [NUM_PERIPHS-1:0][usb_packet_width-1:0]  periph_rx_data,
  input  logic [NUM_PERIPHS-1:0]                        periph_rx_empty,
  input  logic [NUM_PERIPHS-1:0]                        periph_rx_almost_full,
  input  logic [NUM_PERIPHS-1:0]                        periph_ready,
  output logic [NUM_PERIPHS-1:0]                        periph_rx_read,
  output logic [usb_packet_width-1:0]                   usb_data,
  output logic                                          usb_valid,
  input  logic                                          usb_full,
  output logic [periph_address_width-1:0]               grant_id,
  output logic                                          busy
);

  localparam int AW = periph_address_width;

  localparam logic [AW-1:0] LAST  = AW'(NUM_PERIPHS - 1);
  localparam logic [4:0]    BURST = 5'(BURST_LEN);

  arb_state_t state;

  logic [NUM_PERIPHS-1:0] req;
  logic [NUM_PERIPHS-1:0] hot_req;
  logic [AW-1:0]          ptr;
  logic [3:0]             cnt;
  logic [4:0]             cnt_inc;
  logic                   more;
  logic                   hot_found;
  logic                   all_found;
  logic [AW-1:0]          hot_idx;
  logic [AW-1:0]          all_idx;
  logic [AW-1:0]          sel;
  logic [AW-1:0]          sel_nxt;
  logic                   gnt_req;

  function automatic logic [NUM_PERIPHS-1:0] onehot(
    input logic [AW-1:0] i
  );
    onehot    = '0;
    onehot[i] = 1'b1;
  endfunction

  assign req     = periph_ready & ~periph_rx_empty;
  assign hot_req = req & periph_rx_almost_full;

  rr_priority_select #(
    .N  (NUM_PERIPHS),
    .AW (AW)
  ) u_hot (
    .req   (hot_req),
    .start (ptr),
    .found (hot_found),
    .idx   (hot_idx)
  );

  rr_priority_select #(
    .N  (NUM_PERIPHS),
    .AW (AW)
  ) u_all (
    .req   (req),
    .start (ptr),
    .found (all_found),
    .idx   (all_idx)
  );

  // Almost-full requesters take precedence over plain requesters
  always_comb begin
    sel     = hot_found ? hot_idx : all_idx;
    sel_nxt = (sel == LAST) ? '0 : sel + 1'b1;
    gnt_req = req[grant_id];
    cnt_inc = {1'b0, cnt} + 5'd1;
    more    = cnt_inc < BURST;
  end

  // Arbitration FSM with registered strobe, data and status outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      usb_valid      <= 1'b0;
      usb_data       <= '0;
      periph_rx_read <= '0;
      grant_id       <= '0;
      busy           <= 1'b0;
      cnt            <= '0;
      ptr            <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (all_found) begin
            grant_id       <= sel;
            ptr            <= sel_nxt;
            periph_rx_read <= onehot(sel);
            busy           <= 1'b1;
            state          <= ISSUE;
          end
        end
        ISSUE: begin
          periph_rx_read <= '0;
          state          <= CAPTURE;
        end
        CAPTURE: begin
          usb_data  <= periph_rx_data[grant_id];
          usb_valid <= 1'b1;
          state     <= SEND;
        end
        SEND: begin
          if (!usb_full) begin
            usb_valid <= 1'b0;
            if (gnt_req && more) begin
              cnt            <= cnt_inc[3:0];
              periph_rx_read <= onehot(grant_id);
              state          <= ISSUE;
            end else begin
              cnt   <= '0;
              busy  <= 1'b0;
              state <= IDLE;
            end
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
